// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use stalls, control-transfer
// flushes and drain-then-halt on a halting ecall. Define HAZARD_STALL_COUNTER_EN for stall_cycles.
module hazard_control_unit #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_ecall,
  input  logic             id_x17_eq_10,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       is_halted_q;
  logic       luh;

  // A load targeting x0 never produces a value, so it can never create a hazard.
  assign luh = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!reset) begin
      case (state_q)
        StRun: begin
          if (ex_flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (luh) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_is_ecall && id_x17_eq_10) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = StDrain;
            drain_cnt_d  = DrainInit;
          end
        end
        StDrain: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (drain_cnt_q == 4'd0) begin
            state_d = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
        StHalted: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      drain_cnt_q <= 4'd0;
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      is_halted_q <= (state_d == StHalted);
    end
  end

  assign is_halted = is_halted_q;

`ifdef HAZARD_STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_q;
  logic             stall_inc;

  assign stall_inc = (state_q == StRun) && !ex_flush && luh;

  // Saturating so a long run never reports a misleadingly small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
